thread_lsu: RTL and testbench
=============================

Name: thread_lsu

Overview:
- Per-thread load/store unit. Sits directly upstream of the data-memory controller as one of its NUM_CONSUMERS consumers.
- Turns decoded LDR/STR instructions into single-request valid/ready transactions on the controller's consumer port.
- Captures the returned load data and reports progress to the core scheduler through lsu_state.

Parameters:
- ADDR_BITS, 8, memory address width; must match the controller.
- DATA_BITS, 8, data word width; must match the controller.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  thread is active in the current block; when low the unit stays IDLE.
- core_state  input  3  scheduler state (core_state_t).
- decoded_mem_read_enable  input  1  current instruction is LDR.
- decoded_mem_write_enable  input  1  current instruction is STR.
- rs  input  DATA_BITS  address operand; low ADDR_BITS bits are used.
- rt  input  DATA_BITS  store data operand.
- mem_read_valid  output  1  read request to controller.
- mem_read_address  output  ADDR_BITS  read address.
- mem_read_ready  input  1  controller grant/data-valid strobe for reads.
- mem_read_data  input  DATA_BITS  read data; valid when mem_read_ready is high.
- mem_write_valid  output  1  write request to controller.
- mem_write_address  output  ADDR_BITS  write address.
- mem_write_data  output  DATA_BITS  write data.
- mem_write_ready  input  1  controller write-accept strobe.
- lsu_state  output  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
- lsu_out  output  DATA_BITS  last loaded word.

Behaviour:
- Clock and reset: single clock domain (clk). Reset is asynchronous, active-high; it acts immediately, independent of clk.
- Reset values: lsu_state=IDLE. mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data and lsu_out are all 0.
- All outputs are registered.
- IDLE -> REQUESTING: when enable=1, core_state==REQUEST, and either decoded enable is high.
  - If both enables are high, the read wins and the write is dropped for that instruction.
  - If neither enable is high, stay IDLE.
- REQUESTING (one cycle):
  - Read: latch mem_read_address=rs[ADDR_BITS-1:0] and assert mem_read_valid.
  - Write: also latch mem_write_data=rt and assert mem_write_valid.
  - Go to WAITING.
- WAITING:
  - Hold valid, address and data stable until the matching ready strobe is seen high at a clock edge.
  - Read: on mem_read_ready=1, lsu_out<=mem_read_data, mem_read_valid<=0, go to DONE.
  - Write: on mem_write_ready=1, mem_write_valid<=0, go to DONE.
  - No timeout; waiting is unbounded.
- DONE: hold until core_state==UPDATE, then go to IDLE. lsu_out holds its value until the next completed load.
- Latency: at least 3 cycles from the REQUEST edge to DONE (REQUESTING, then WAITING for at least one cycle), because the controller's ready is registered.
- Stray strobes:
  - A ready strobe seen in any state other than WAITING is ignored, and so is the wrong-type strobe in WAITING. This covers a duplicate grant caused by the controller sampling valid on the same edge it was dropped.
  - A ready strobe in the same cycle as entry to WAITING is not possible (valid was asserted on that edge).
- enable dropped mid-operation: the transaction still completes. enable only gates the IDLE->REQUESTING transition.
- core_state changes while in WAITING (other than to UPDATE) are ignored.
- Reset mid-operation: all state clears immediately. Any outstanding controller grant arriving afterwards is ignored because the unit is in IDLE.
- Address width: rs is truncated to ADDR_BITS when ADDR_BITS < DATA_BITS, and zero-extended when ADDR_BITS > DATA_BITS.

Decomposition:
- Shared package gpu_pkg holds:
  - core_state_t (3 bits): IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
  - lsu_state_t (2 bits): IDLE, REQUESTING, WAITING, DONE.
- No sub-module. One next-state block plus one registered output block.

Test Plan:
- Load: rs=0x2A, read_enable=1, core_state=REQUEST; ready plus data=0x5C returned 2 cycles after valid -> mem_read_address=0x2A held while waiting; lsu_out=0x5C; lsu_state DONE; IDLE after core_state=UPDATE.
- Store: rs=0x10, rt=0xA7, write_enable=1 -> mem_write_address=0x10 and mem_write_data=0xA7 stable until write_ready; valid drops on the ready edge; DONE; lsu_out unchanged.
- Back-pressure: withhold mem_read_ready for 20 cycles -> state WAITING, valid and address unchanged all 20 cycles; completes on the first ready.
- Conflict and gating:
  - Both enables high -> only mem_read_valid asserts.
  - enable=0 at REQUEST -> stays IDLE, no valid asserted.
- Stray strobes: mem_read_ready pulsed while in DONE, and mem_write_ready pulsed during a load -> no state change, lsu_out unchanged.
- Async reset: assert reset mid-WAITING between clock edges -> valids and state clear immediately; a following ready strobe is ignored.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared scheduler and load/store unit state encodings for the GPU core.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: one valid/ready request per LDR/STR to the
// data-memory controller, with progress reported through lsu_state.
module thread_lsu
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out
);

  lsu_state_t           r_state;
  lsu_state_t           w_state_next;
  logic                 r_is_read;
  logic                 r_rd_valid;
  logic                 r_wr_valid;
  logic [ADDR_BITS-1:0] r_rd_addr;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [DATA_BITS-1:0] r_wr_data;
  logic [DATA_BITS-1:0] r_out;
  logic [ADDR_BITS-1:0] w_rs_addr;
  logic                 w_done_strobe;

  // Fit the address operand to the controller's address width.
  generate
    if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
      assign w_rs_addr = rs[ADDR_BITS-1:0];
    end else begin : g_addr_zext
      assign w_rs_addr = {{(ADDR_BITS - DATA_BITS){1'b0}}, rs};
    end
  endgenerate

  // Only the strobe matching the outstanding request type completes it.
  assign w_done_strobe = r_is_read ? mem_read_ready : mem_write_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (enable && (core_state == CORE_REQUEST) &&
            (decoded_mem_read_enable || decoded_mem_write_enable)) begin
          w_state_next = LSU_REQUESTING;
        end
      end
      LSU_REQUESTING: w_state_next = LSU_WAITING;
      LSU_WAITING: begin
        if (w_done_strobe) begin
          w_state_next = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (core_state == CORE_UPDATE) begin
          w_state_next = LSU_IDLE;
        end
      end
      default: w_state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= LSU_IDLE;
      r_is_read  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_out      <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        LSU_IDLE: begin
          // A read wins when both decoded enables are set.
          if (w_state_next == LSU_REQUESTING) begin
            r_is_read <= decoded_mem_read_enable;
          end
        end
        LSU_REQUESTING: begin
          if (r_is_read) begin
            r_rd_addr  <= w_rs_addr;
            r_rd_valid <= 1'b1;
          end else begin
            r_wr_addr  <= w_rs_addr;
            r_wr_data  <= rt;
            r_wr_valid <= 1'b1;
          end
        end
        LSU_WAITING: begin
          if (r_is_read && mem_read_ready) begin
            r_out      <= mem_read_data;
            r_rd_valid <= 1'b0;
          end else if (!r_is_read && mem_write_ready) begin
            r_wr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign lsu_state         = r_state;
  assign lsu_out           = r_out;
  assign mem_read_valid    = r_rd_valid;
  assign mem_read_address  = r_rd_addr;
  assign mem_write_valid   = r_wr_valid;
  assign mem_write_address = r_wr_addr;
  assign mem_write_data    = r_wr_data;

endmodule

// File: tb/tb_thread_lsu.sv
// Scoreboard bench for thread_lsu: stimulus queues expected requests and
// completions, a negedge monitor checks them as the unit presents them.
module tb_thread_lsu;
  import gpu_pkg::*;

  localparam logic [1:0] K_RD   = 2'd0;
  localparam logic [1:0] K_WR   = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       decoded_mem_read_enable;
  logic       decoded_mem_write_enable;
  logic [7:0] rs;
  logic [7:0] rt;
  logic       mem_read_valid;
  logic [7:0] mem_read_address;
  logic       mem_read_ready;
  logic [7:0] mem_read_data;
  logic       mem_write_valid;
  logic [7:0] mem_write_address;
  logic [7:0] mem_write_data;
  logic       mem_write_ready;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] model_out = 8'h00;

  logic       p_rd_v = 1'b0;
  logic       p_wr_v = 1'b0;
  logic [7:0] p_rd_a = 8'h00;
  logic [7:0] p_wr_a = 8'h00;
  logic [7:0] p_wr_d = 8'h00;
  logic [1:0] p_state = 2'd0;

  always #5 clk = ~clk;

  thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (decoded_mem_read_enable),
    .decoded_mem_write_enable (decoded_mem_write_enable),
    .rs                       (rs),
    .rt                       (rt),
    .mem_read_valid           (mem_read_valid),
    .mem_read_address         (mem_read_address),
    .mem_read_ready           (mem_read_ready),
    .mem_read_data            (mem_read_data),
    .mem_write_valid          (mem_write_valid),
    .mem_write_address        (mem_write_address),
    .mem_write_data           (mem_write_data),
    .mem_write_ready          (mem_write_ready),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever a request rises or DONE is entered.
  always @(negedge clk) begin
    exp_t e;
    if (mem_read_valid && !p_rd_v) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rd_req: unexpected read request addr=%0h", mem_read_address);
      end else begin
        e = sb.pop_front();
        if (e.kind != K_RD || mem_read_address != e.addr) begin
          n_err++;
          $display("FAIL rd_req: got read addr=%0h expected kind=%0d addr=%0h",
                   mem_read_address, e.kind, e.addr);
        end
      end
    end
    if (mem_write_valid && !p_wr_v) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wr_req: unexpected write request addr=%0h", mem_write_address);
      end else begin
        e = sb.pop_front();
        if (e.kind != K_WR || mem_write_address != e.addr || mem_write_data != e.data) begin
          n_err++;
          $display("FAIL wr_req: got write addr=%0h data=%0h expected kind=%0d addr=%0h data=%0h",
                   mem_write_address, mem_write_data, e.kind, e.addr, e.data);
        end
      end
    end
    if (lsu_state == 2'd3 && p_state != 2'd3) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL done: unexpected DONE lsu_out=%0h", lsu_out);
      end else begin
        e = sb.pop_front();
        if (e.kind != K_DONE || lsu_out != e.data) begin
          n_err++;
          $display("FAIL done: got lsu_out=%0h expected kind=%0d lsu_out=%0h",
                   lsu_out, e.kind, e.data);
        end
      end
    end
    if (p_rd_v && mem_read_valid) begin
      n_cmp++;
      if (mem_read_address != p_rd_a) begin
        n_err++;
        $display("FAIL rd_hold: got addr=%0h expected %0h", mem_read_address, p_rd_a);
      end
    end
    if (p_wr_v && mem_write_valid) begin
      n_cmp++;
      if (mem_write_address != p_wr_a || mem_write_data != p_wr_d) begin
        n_err++;
        $display("FAIL wr_hold: got addr=%0h data=%0h expected addr=%0h data=%0h",
                 mem_write_address, mem_write_data, p_wr_a, p_wr_d);
      end
    end
    p_rd_v  = mem_read_valid;
    p_wr_v  = mem_write_valid;
    p_rd_a  = mem_read_address;
    p_wr_a  = mem_write_address;
    p_wr_d  = mem_write_data;
    p_state = lsu_state;
  end

  task automatic do_op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rdata, input int wcyc, input bit stray);
    if (rd) sb.push_back({K_RD, a, 8'h00});
    else    sb.push_back({K_WR, a, d});
    if (rd) model_out = rdata;
    sb.push_back({K_DONE, 8'h00, model_out});

    enable = 1'b1;
    decoded_mem_read_enable  = rd;
    decoded_mem_write_enable = wr;
    rs = a;
    rt = d;
    core_state = CORE_REQUEST;
    tick();
    chk("requesting", 32'(lsu_state), 32'd1);
    core_state = CORE_WAIT;
    tick();
    chk("waiting", 32'(lsu_state), 32'd2);
    chk("rd_valid_on", 32'(mem_read_valid), 32'(rd));
    chk("wr_valid_on", 32'(mem_write_valid), 32'(!rd));
    if (stray) begin
      if (rd) mem_write_ready = 1'b1;
      else begin
        mem_read_ready = 1'b1;
        mem_read_data  = 8'hEE;
      end
    end
    for (int i = 0; i < wcyc; i++) begin
      tick();
      chk("hold_waiting", 32'(lsu_state), 32'd2);
    end
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    if (rd) begin
      mem_read_ready = 1'b1;
      mem_read_data  = rdata;
    end else begin
      mem_write_ready = 1'b1;
    end
    tick();
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'h00;
    chk("done_state", 32'(lsu_state), 32'd3);
    chk("rd_valid_off", 32'(mem_read_valid), 32'd0);
    chk("wr_valid_off", 32'(mem_write_valid), 32'd0);

    core_state      = CORE_EXECUTE;
    mem_read_ready  = 1'b1;
    mem_write_ready = 1'b1;
    mem_read_data   = 8'hEE;
    tick();
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'h00;
    chk("done_hold", 32'(lsu_state), 32'd3);
    chk("lsu_out_hold", 32'(lsu_out), 32'(model_out));

    core_state = CORE_UPDATE;
    tick();
    chk("back_idle", 32'(lsu_state), 32'd0);
    core_state = CORE_FETCH;
    decoded_mem_read_enable  = 1'b0;
    decoded_mem_write_enable = 1'b0;
    $display("op rd=%0d wr=%0d addr=%0h wdata=%0h rdata=%0h wait=%0d stray=%0d lsu_out=%0h",
             rd, wr, a, d, rdata, wcyc, stray, lsu_out);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    core_state = CORE_IDLE;
    decoded_mem_read_enable  = 1'b0;
    decoded_mem_write_enable = 1'b0;
    rs = 8'h00;
    rt = 8'h00;
    mem_read_ready  = 1'b0;
    mem_read_data   = 8'h00;
    mem_write_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(lsu_state), 32'd0);
    chk("rst_rd_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_wr_valid", 32'(mem_write_valid), 32'd0);
    chk("rst_outs", {mem_read_address, mem_write_address, mem_write_data, lsu_out}, 32'd0);
    reset = 1'b0;
    tick();

    do_op(1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C, 1,  1'b0);
    do_op(1'b0, 1'b1, 8'h10, 8'hA7, 8'h00, 2,  1'b1);
    do_op(1'b1, 1'b0, 8'h33, 8'h00, 8'hC3, 20, 1'b0);
    do_op(1'b1, 1'b1, 8'h44, 8'h11, 8'h6E, 0,  1'b0);
    do_op(1'b1, 1'b0, 8'hFF, 8'h00, 8'h01, 3,  1'b1);
    do_op(1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 0,  1'b0);

    // Gating: enable low, then no decoded enable; stray strobes in IDLE.
    enable = 1'b0;
    decoded_mem_read_enable = 1'b1;
    rs = 8'h55;
    core_state = CORE_REQUEST;
    mem_read_ready = 1'b1;
    mem_read_data  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gate_enable_state", 32'(lsu_state), 32'd0);
      chk("gate_enable_valid", 32'(mem_read_valid), 32'd0);
    end
    enable = 1'b1;
    decoded_mem_read_enable = 1'b0;
    mem_write_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gate_noop_state", 32'(lsu_state), 32'd0);
      chk("gate_noop_valid", 32'({mem_read_valid, mem_write_valid}), 32'd0);
    end
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'h00;
    chk("gate_lsu_out", 32'(lsu_out), 32'(model_out));
    $display("op gating enable=0 and no-decode: stayed IDLE lsu_out=%0h", lsu_out);
    core_state = CORE_FETCH;
    tick();

    // Asynchronous reset while WAITING, then a late grant.
    sb.push_back({K_RD, 8'h77, 8'h00});
    decoded_mem_read_enable = 1'b1;
    rs = 8'h77;
    core_state = CORE_REQUEST;
    tick();
    core_state = CORE_WAIT;
    tick();
    tick();
    chk("pre_reset_waiting", 32'(lsu_state), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    model_out = 8'h00;
    chk("async_rst_state", 32'(lsu_state), 32'd0);
    chk("async_rst_valid", 32'(mem_read_valid), 32'd0);
    chk("async_rst_addr", 32'(mem_read_address), 32'd0);
    chk("async_rst_out", 32'(lsu_out), 32'(model_out));
    #2;
    reset = 1'b0;
    enable = 1'b0;
    decoded_mem_read_enable = 1'b0;
    core_state = CORE_FETCH;
    mem_read_ready = 1'b1;
    mem_read_data  = 8'h99;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = 8'h00;
    chk("late_grant_state", 32'(lsu_state), 32'd0);
    chk("late_grant_out", 32'(lsu_out), 32'(model_out));
    tick();
    chk("late_grant_valid", 32'(mem_read_valid), 32'd0);
    $display("op async reset mid-wait: state=%0d lsu_out=%0h", lsu_state, lsu_out);

    tick();
    tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
